// File: rtl/fitness_telemetry_if.sv
`default_nettype none
// ============================================================================
// Module   : fitness_telemetry_if
// Brief    : Request/statistics/serial-status bundle for the telemetry transmitter.
// Revision : 1.0
// ============================================================================
interface fitness_telemetry_if;
  logic        send_req;
  logic [15:0] total_steps;
  logic [31:0] total_distance;
  logic [7:0]  time_elapsed;
  logic [7:0]  max_heart_rate;
  logic [1:0]  hr_class;
  logic [1:0]  workout_intensity;
  logic [31:0] average_heart_rate;
  logic [15:0] speed;
  logic        tx;
  logic        busy;
  logic        frame_done;
  logic [7:0]  drop_count;

  modport master (
    output send_req, total_steps, total_distance, time_elapsed, max_heart_rate,
           hr_class, workout_intensity, average_heart_rate, speed,
    input  tx, busy, frame_done, drop_count
  );

  modport slave (
    input  send_req, total_steps, total_distance, time_elapsed, max_heart_rate,
           hr_class, workout_intensity, average_heart_rate, speed,
    output tx, busy, frame_done, drop_count
  );
endinterface
`default_nettype wire

// File: rtl/fitness_telemetry_tx.sv
`default_nettype none
// ============================================================================
// Module   : fitness_telemetry_tx
// Brief    : Snapshots fitness statistics and sends a 13-byte serial frame.
//            Define TELEM_PARITY_EN to add an even-parity bit per character.
// Revision : 1.0
// ============================================================================
module fitness_telemetry_tx #(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] HEADER_BYTE  = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst,
  fitness_telemetry_if.slave   link
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        LAST_BYTE = 4'd12;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
`ifdef TELEM_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif

  logic [2:0]        state;
  logic [2:0]        state_next;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [3:0]        byte_idx;
  logic              tx_line;
  logic              tx_next;
  logic              done_pulse;
  logic              done_next;
  logic [7:0]        drops;

  logic [15:0] sh_steps;
  logic [31:0] sh_distance;
  logic [7:0]  sh_time;
  logic [7:0]  sh_max_hr;
  logic [3:0]  sh_class;
  logic [7:0]  sh_avg;
  logic [7:0]  sh_speed;

  logic       bit_end;
  logic       busy;
  logic       last_byte;
  logic [7:0] checksum;
  logic [7:0] cur_byte;

  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign busy      = (state != IDLE);
  assign last_byte = (byte_idx == LAST_BYTE);

  assign checksum = sh_steps[15:8] ^ sh_steps[7:0]
                  ^ sh_distance[31:24] ^ sh_distance[23:16]
                  ^ sh_distance[15:8]  ^ sh_distance[7:0]
                  ^ sh_time ^ sh_max_hr ^ {4'b0000, sh_class}
                  ^ sh_avg ^ sh_speed;

  always_comb begin
    cur_byte = checksum;
    case (byte_idx)
      4'd0:    cur_byte = HEADER_BYTE;
      4'd1:    cur_byte = sh_steps[15:8];
      4'd2:    cur_byte = sh_steps[7:0];
      4'd3:    cur_byte = sh_distance[31:24];
      4'd4:    cur_byte = sh_distance[23:16];
      4'd5:    cur_byte = sh_distance[15:8];
      4'd6:    cur_byte = sh_distance[7:0];
      4'd7:    cur_byte = sh_time;
      4'd8:    cur_byte = sh_max_hr;
      4'd9:    cur_byte = {4'b0000, sh_class};
      4'd10:   cur_byte = sh_avg;
      4'd11:   cur_byte = sh_speed;
      default: cur_byte = checksum;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (link.send_req) state_next = START;
      START: if (bit_end) state_next = DATA;
      DATA:
        if (bit_end && bit_idx == 3'd7) begin
`ifdef TELEM_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
`ifdef TELEM_PARITY_EN
      PARITY: if (bit_end) state_next = STOP;
`endif
      STOP:  if (bit_end) state_next = last_byte ? IDLE : START;
      default: state_next = IDLE;
    endcase
  end

  // tx is registered: these values describe the line level for the next bit period.
  always_comb begin
    tx_next   = tx_line;
    done_next = 1'b0;
    case (state)
      IDLE:  tx_next = ~link.send_req;
      START: if (bit_end) tx_next = cur_byte[0];
      DATA:
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
`ifdef TELEM_PARITY_EN
            tx_next = ^cur_byte;
`else
            tx_next = 1'b1;
`endif
          end else begin
            tx_next = cur_byte[bit_idx + 3'd1];
          end
        end
`ifdef TELEM_PARITY_EN
      PARITY: if (bit_end) tx_next = 1'b1;
`endif
      STOP:
        if (bit_end) begin
          tx_next   = last_byte;
          done_next = last_byte;
        end
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_line     <= 1'b1;
      done_pulse  <= 1'b0;
      drops       <= 8'd0;
      baud_cnt    <= '0;
      bit_idx     <= 3'd0;
      byte_idx    <= 4'd0;
      sh_steps    <= 16'd0;
      sh_distance <= 32'd0;
      sh_time     <= 8'd0;
      sh_max_hr   <= 8'd0;
      sh_class    <= 4'd0;
      sh_avg      <= 8'd0;
      sh_speed    <= 8'd0;
    end else begin
      tx_line    <= tx_next;
      done_pulse <= done_next;
      if (link.send_req && busy && drops != 8'hFF) drops <= drops + 8'd1;
      if (state == IDLE) begin
        baud_cnt <= '0;
        bit_idx  <= 3'd0;
        byte_idx <= 4'd0;
        if (link.send_req) begin
          sh_steps    <= link.total_steps;
          sh_distance <= link.total_distance;
          sh_time     <= link.time_elapsed;
          sh_max_hr   <= link.max_heart_rate;
          sh_class    <= {link.workout_intensity, link.hr_class};
          // Wide averages/speeds are clamped to one byte at capture time.
          sh_avg      <= (|link.average_heart_rate[31:8]) ? 8'hFF : link.average_heart_rate[7:0];
          sh_speed    <= (|link.speed[15:8]) ? 8'hFF : link.speed[7:0];
        end
      end else begin
        baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
        if (bit_end && state == DATA) bit_idx <= bit_idx + 3'd1;
        if (bit_end && state == STOP && !last_byte) byte_idx <= byte_idx + 4'd1;
      end
    end
  end

  assign link.tx         = tx_line;
  assign link.busy       = busy;
  assign link.frame_done = done_pulse;
  assign link.drop_count = drops;

endmodule
`default_nettype wire
